// File: rtl/writeback_pkg.sv
// Shared encodings and widths for the LC-3 writeback stage and its register file.
package writeback_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_src_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  // Condition codes derived from a value being written back.
  function automatic logic [2:0] calc_psr(input logic [DATA_W-1:0] value);
    logic [2:0] cc;
    if (value[DATA_W-1])
      cc = PSR_N;
    else if (value == '0)
      cc = PSR_Z;
    else
      cc = PSR_P;
    return cc;
  endfunction

endpackage

// File: rtl/writeback_regfile.sv
// Eight-entry register file: one synchronous write port, two combinational read ports.
module writeback_regfile
  import writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle write is visible only after the edge.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: selects write data, updates the register file and condition codes.
module lc3_writeback
  import writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [1:0]        W_Control_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic              enable_writeback,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  logic [DATA_W-1:0] wb_data;

  always_comb begin
    wb_data = aluout;
    case (wb_src_e'(W_Control_in))
      WB_ALU: wb_data = aluout;
      WB_MEM: wb_data = memout;
      WB_PC:  wb_data = pcout;
      WB_NPC: wb_data = npc_in;
      default: wb_data = aluout;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      psr <= 3'b000;
    else if (enable_writeback)
      psr <= calc_psr(wb_data);
  end

  writeback_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (enable_writeback),
    .waddr  (dr),
    .wdata  (wb_data),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (VSR1),
    .rdata2 (VSR2)
  );

endmodule
